param_circular_fifo: RTL and testbench

- Parametrised single-clock circular FIFO; next generation of the team's fixed 8-bit single-clock circular FIFO.
- Adds configurable width and depth, an occupancy count, and programmable almost-full/almost-empty thresholds.
- Adds overflow/underflow error pulses and a selectable show-ahead (FWFT) read mode.
- Sits between producer and consumer logic in the same clock domain; drop-in for the old block when SHOW_AHEAD=0, DATA_W=8, DEPTH=8.

---
 rtl/param_fifo_pkg.sv | 12 +
 rtl/fifo_mem_dp.sv | 25 ++
 rtl/param_circular_fifo.sv | 114 +++++++++++
 tb/tb_param_circular_fifo.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_fifo_pkg.sv
// Shared constants and helpers for the parametrised circular FIFO.
package param_fifo_pkg;

    localparam int DEFAULT_AE_LEVEL  = 2;
    // almost_full default sits this many entries below DEPTH
    localparam int DEFAULT_AF_MARGIN = 2;

    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module fifo_mem_dp #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int PW     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_circular_fifo.sv
// Single-clock circular FIFO with occupancy count, thresholds, error pulses
// and selectable registered / show-ahead read.
module param_circular_fifo
    import param_fifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - DEFAULT_AF_MARGIN,
    parameter int AE_LEVEL   = DEFAULT_AE_LEVEL,
    parameter int SHOW_AHEAD = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     wr,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     rd,
    output logic [DATA_W-1:0]        data_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [ptr_w(DEPTH):0]    count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;
    logic              overflow_reg;
    logic              underflow_reg;
    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_data;

    assign empty        = (count_reg == '0);
    assign full         = (count_reg == CW'(DEPTH));
    assign almost_empty = (int'(count_reg) <= AE_LEVEL);
    assign almost_full  = (int'(count_reg) >= AF_LEVEL);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // Read is resolved first so a full FIFO can accept a concurrent write.
    assign rd_ok = enable & rd & ~empty;
    assign wr_ok = enable & wr & (~full | rd_ok);

    always_comb begin
        count_next = count_reg;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg     <= count_next;
            overflow_reg  <= enable & wr & ~wr_ok;
            underflow_reg <= enable & rd & ~rd_ok;
        end
    end

    fifo_mem_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PW     (PW)
    ) u_mem (
        .clk     (clk),
        .we      (wr_ok),
        .wr_addr (wr_ptr_reg),
        .wr_data (data_in),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    generate
        if (SHOW_AHEAD == 0) begin : g_reg_read
            logic [DATA_W-1:0] data_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_reg <= '0;
                end else if (rd_ok) begin
                    data_reg <= rd_data;
                end
            end

            assign data_out = data_reg;
        end else begin : g_fwft
            // Head word is presented directly; forced to zero while empty.
            assign data_out = empty ? '0 : rd_data;
        end
    endgenerate

endmodule

// File: tb/tb_param_circular_fifo.sv
// Directed bench for param_circular_fifo: default, DEPTH=4 and show-ahead instances.
module tb_param_circular_fifo;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: defaults (DATA_W=8, DEPTH=8, SHOW_AHEAD=0)
    logic       a_en = 1'b1, a_wr = 1'b0, a_rd = 1'b0;
    logic [7:0] a_din = '0, a_dout;
    logic       a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
    logic [3:0] a_cnt;

    // Instance B: DEPTH=4
    logic       b_en = 1'b1, b_wr = 1'b0, b_rd = 1'b0;
    logic [7:0] b_din = '0, b_dout;
    logic       b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
    logic [2:0] b_cnt;

    // Instance C: SHOW_AHEAD=1
    logic       c_en = 1'b1, c_wr = 1'b0, c_rd = 1'b0;
    logic [7:0] c_din = '0, c_dout;
    logic       c_empty, c_full, c_ae, c_af, c_ovf, c_unf;
    logic [3:0] c_cnt;

    param_circular_fifo #(.DATA_W(8), .DEPTH(8)) dut_a (
        .clk(clk), .rst(rst), .enable(a_en), .wr(a_wr), .data_in(a_din), .rd(a_rd),
        .data_out(a_dout), .empty(a_empty), .full(a_full), .almost_empty(a_ae),
        .almost_full(a_af), .count(a_cnt), .overflow(a_ovf), .underflow(a_unf));

    param_circular_fifo #(.DATA_W(8), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .enable(b_en), .wr(b_wr), .data_in(b_din), .rd(b_rd),
        .data_out(b_dout), .empty(b_empty), .full(b_full), .almost_empty(b_ae),
        .almost_full(b_af), .count(b_cnt), .overflow(b_ovf), .underflow(b_unf));

    param_circular_fifo #(.DATA_W(8), .DEPTH(8), .SHOW_AHEAD(1)) dut_c (
        .clk(clk), .rst(rst), .enable(c_en), .wr(c_wr), .data_in(c_din), .rd(c_rd),
        .data_out(c_dout), .empty(c_empty), .full(c_full), .almost_empty(c_ae),
        .almost_full(c_af), .count(c_cnt), .overflow(c_ovf), .underflow(c_unf));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (a_cnt !== 4'd0 || a_empty !== 1'b1 || a_full !== 1'b0 || a_ae !== 1'b1 ||
            a_af !== 1'b0 || a_ovf !== 1'b0 || a_unf !== 1'b0 || a_dout !== 8'h00) begin
            failures++;
            $display("FAIL reset_a: cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b dout=%h required cnt=0 e=1 f=0 ae=1 af=0 ov=0 un=0 dout=00",
                     a_cnt, a_empty, a_full, a_ae, a_af, a_ovf, a_unf, a_dout);
        end
        checks++;
        if (c_dout !== 8'h00 || c_empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_c: dout=%h empty=%b required dout=00 empty=1", c_dout, c_empty);
        end
        @(negedge clk);
        rst = 1'b1;
        cyc();
        $display("test_reset done");
    endtask

    task automatic fill_a(input int n);
        for (int i = 1; i <= n; i++) begin
            a_wr = 1'b1; a_din = 8'(i);
            cyc();
        end
        a_wr = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            a_wr = 1'b1; a_din = 8'(i);
            cyc();
            checks++;
            if (a_cnt !== 4'(i) || a_full !== (i == 8) || a_af !== (i >= 6) || a_ae !== (i <= 2)) begin
                failures++;
                $display("FAIL fill_%0d: cnt=%0d full=%b af=%b ae=%b required cnt=%0d full=%b af=%b ae=%b",
                         i, a_cnt, a_full, a_af, a_ae, i, i == 8, i >= 6, i <= 2);
            end
        end
        a_wr = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            a_rd = 1'b1;
            cyc();
            checks++;
            if (i <= 8) begin
                if (a_dout !== 8'(i) || a_unf !== 1'b0 || a_cnt !== 4'(8 - i)) begin
                    failures++;
                    $display("FAIL drain_%0d: dout=%h unf=%b cnt=%0d required dout=%h unf=0 cnt=%0d",
                             i, a_dout, a_unf, a_cnt, 8'(i), 8 - i);
                end
            end else if (a_dout !== 8'h08 || a_unf !== 1'b1 || a_empty !== 1'b1) begin
                failures++;
                $display("FAIL drain_underflow: dout=%h unf=%b empty=%b required dout=08 unf=1 empty=1",
                         a_dout, a_unf, a_empty);
            end
        end
        a_rd = 1'b0;
        cyc();
        checks++;
        if (a_unf !== 1'b0) begin
            failures++;
            $display("FAIL underflow_pulse: unf=%b required 0", a_unf);
        end
        $display("test_fill_drain done");
    endtask

    task automatic test_overflow();
        fill_a(8);
        a_wr = 1'b1; a_din = 8'hAA;
        cyc();
        a_wr = 1'b0;
        checks++;
        if (a_ovf !== 1'b1 || a_cnt !== 4'd8) begin
            failures++;
            $display("FAIL overflow: ovf=%b cnt=%0d required ovf=1 cnt=8", a_ovf, a_cnt);
        end
        cyc();
        checks++;
        if (a_ovf !== 1'b0) begin
            failures++;
            $display("FAIL overflow_pulse: ovf=%b required 0", a_ovf);
        end
        for (int i = 1; i <= 8; i++) begin
            a_rd = 1'b1;
            cyc();
            checks++;
            if (a_dout !== 8'(i)) begin
                failures++;
                $display("FAIL overflow_read_%0d: dout=%h required %h", i, a_dout, 8'(i));
            end
        end
        a_rd = 1'b0;
        cyc();
        $display("test_overflow done");
    endtask

    task automatic test_simultaneous();
        fill_a(8);
        a_wr = 1'b1; a_din = 8'd9; a_rd = 1'b1;
        cyc();
        a_wr = 1'b0;
        checks++;
        if (a_cnt !== 4'd8 || a_dout !== 8'd1 || a_ovf !== 1'b0) begin
            failures++;
            $display("FAIL simul_full: cnt=%0d dout=%h ovf=%b required cnt=8 dout=01 ovf=0", a_cnt, a_dout, a_ovf);
        end
        for (int i = 2; i <= 9; i++) begin
            cyc();
            checks++;
            if (a_dout !== 8'(i)) begin
                failures++;
                $display("FAIL simul_read_%0d: dout=%h required %h", i, a_dout, 8'(i));
            end
        end
        a_wr = 1'b1; a_din = 8'd5; a_rd = 1'b1;
        cyc();
        a_wr = 1'b0;
        checks++;
        if (a_unf !== 1'b1 || a_cnt !== 4'd1) begin
            failures++;
            $display("FAIL simul_empty: unf=%b cnt=%0d required unf=1 cnt=1", a_unf, a_cnt);
        end
        cyc();
        a_rd = 1'b0;
        checks++;
        if (a_dout !== 8'd5 || a_cnt !== 4'd0) begin
            failures++;
            $display("FAIL simul_empty_read: dout=%h cnt=%0d required dout=05 cnt=0", a_dout, a_cnt);
        end
        cyc();
        $display("test_simultaneous done");
    endtask

    task automatic test_wrap();
        int expect_val;
        for (int i = 1; i <= 3; i++) begin
            b_wr = 1'b1; b_din = 8'(i);
            cyc();
        end
        expect_val = 1;
        for (int i = 4; i <= 10; i++) begin
            b_wr = 1'b1; b_din = 8'(i); b_rd = 1'b1;
            cyc();
            checks++;
            if (b_dout !== 8'(expect_val) || b_cnt !== 3'd3) begin
                failures++;
                $display("FAIL wrap_%0d: dout=%h cnt=%0d required dout=%h cnt=3", i, b_dout, b_cnt, 8'(expect_val));
            end
            expect_val++;
        end
        b_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (b_dout !== 8'(expect_val)) begin
                failures++;
                $display("FAIL wrap_drain_%0d: dout=%h required %h", expect_val, b_dout, 8'(expect_val));
            end
            expect_val++;
        end
        b_rd = 1'b0;
        cyc();
        checks++;
        if (b_empty !== 1'b1 || b_cnt !== 3'd0) begin
            failures++;
            $display("FAIL wrap_empty: empty=%b cnt=%0d required empty=1 cnt=0", b_empty, b_cnt);
        end
        $display("test_wrap done");
    endtask

    task automatic test_show_ahead();
        c_wr = 1'b1; c_din = 8'h11;
        cyc();
        c_wr = 1'b0;
        checks++;
        if (c_dout !== 8'h11 || c_empty !== 1'b0) begin
            failures++;
            $display("FAIL fwft_head: dout=%h empty=%b required dout=11 empty=0", c_dout, c_empty);
        end
        c_rd = 1'b1;
        cyc();
        c_rd = 1'b0;
        checks++;
        if (c_dout !== 8'h00 || c_empty !== 1'b1) begin
            failures++;
            $display("FAIL fwft_empty: dout=%h empty=%b required dout=00 empty=1", c_dout, c_empty);
        end
        c_wr = 1'b1; c_din = 8'h22;
        cyc();
        c_wr = 1'b0;
        checks++;
        if (c_dout !== 8'h22) begin
            failures++;
            $display("FAIL fwft_second: dout=%h required 22", c_dout);
        end
        $display("test_show_ahead done");
    endtask

    task automatic test_async_reset_enable();
        fill_a(5);
        checks++;
        if (a_cnt !== 4'd5) begin
            failures++;
            $display("FAIL pre_reset_count: cnt=%0d required 5", a_cnt);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (a_cnt !== 4'd0 || a_empty !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: cnt=%0d empty=%b required cnt=0 empty=1", a_cnt, a_empty);
        end
        rst = 1'b1;
        fill_a(3);
        a_rd = 1'b1;
        cyc();
        a_rd = 1'b0;
        a_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_wr = i[0]; a_rd = ~i[0]; a_din = 8'hE0 + 8'(i);
            cyc();
            checks++;
            if (a_cnt !== 4'd2 || a_dout !== 8'd1 || a_ovf !== 1'b0 || a_unf !== 1'b0) begin
                failures++;
                $display("FAIL enable_hold_%0d: cnt=%0d dout=%h ovf=%b unf=%b required cnt=2 dout=01 ovf=0 unf=0",
                         i, a_cnt, a_dout, a_ovf, a_unf);
            end
        end
        a_wr = 1'b0; a_rd = 1'b1; a_en = 1'b1;
        cyc();
        a_rd = 1'b0;
        checks++;
        if (a_dout !== 8'd2 || a_cnt !== 4'd1) begin
            failures++;
            $display("FAIL enable_resume: dout=%h cnt=%0d required dout=02 cnt=1", a_dout, a_cnt);
        end
        $display("test_async_reset_enable done");
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simultaneous();
        test_wrap();
        test_show_ahead();
        test_async_reset_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
